// File: rtl/hit_judge.sv
// hit_judge: judges each lit LED of the hit-or-miss game as a hit or a miss.
// Watches the one-hot LED vector from the randomizer and the player's
// switches. It measures reaction time in coarse ticks and returns it as the
// token fed back to the randomizer. It keeps the score, counts misses and
// ends the game after MAX_MISSES misses.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   led_in     in   [7:0] one-hot LED vector, 0 = no LED lit
//   sw         in   [7:0] raw asynchronous player switches
//   token      out  [7:0] last reaction time in ticks, 8'hFF after a miss
//   hit_pulse  out  one-clk pulse per hit
//   miss_pulse out  one-clk pulse per miss
//   score      out  [SCORE_W-1:0] saturating hit count
//   miss_count out  [3:0] miss count
//   game_over  out  high once miss_count reaches MAX_MISSES
//   busy       out  high while an LED is being judged (ARMED)
module hit_judge #(
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned TIMEOUT_TICKS = 255,
    parameter int unsigned MAX_MISSES    = 3,
    parameter int unsigned SCORE_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         led_in,
    input  logic [7:0]         sw,
    output logic [7:0]         token,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [3:0]         miss_count,
    output logic               game_over,
    output logic               busy
);

    localparam int unsigned PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned LED_W   = 8;
    localparam int unsigned REACT_W = 8;
    localparam int unsigned MISS_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_WAIT  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [LED_W-1:0]     sync1_q, sync1_d;
    logic [LED_W-1:0]     sync2_q, sync2_d;
    logic [LED_W-1:0]     sw_prev_q, sw_prev_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic [LED_W-1:0]     target_q, target_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [REACT_W-1:0]   react_q, react_d;
    logic [REACT_W-1:0]   token_q, token_d;
    logic                 hit_q, hit_d;
    logic                 miss_q, miss_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
    logic                 over_q, over_d;
    logic                 busy_q, busy_d;

    logic [LED_W-1:0]     toggles_c;
    logic                 led_onehot_c;
    logic                 judge_hit_c;
    logic                 judge_miss_c;
    logic                 last_miss_c;

    // Flip detection on the synchronized switches; either direction counts.
    assign toggles_c    = sync2_q ^ sw_prev_q;
    assign led_onehot_c = (led_q != '0) && ((led_q & (led_q - LED_W'(1))) == '0);

    // Judgement priority: stray switch, correct flip, LED expired, timeout.
    always_comb begin
        judge_hit_c  = 1'b0;
        judge_miss_c = 1'b0;
        if (state_q == S_ARMED) begin
            if ((toggles_c & ~target_q) != '0) begin
                judge_miss_c = 1'b1;
            end else if (toggles_c == target_q) begin
                judge_hit_c = 1'b1;
            end else if (led_q == '0) begin
                judge_miss_c = 1'b1;
            end else if (react_q == REACT_W'(TIMEOUT_TICKS)) begin
                judge_miss_c = 1'b1;
            end
        end
    end

    assign last_miss_c = (miss_cnt_q + MISS_W'(1)) == MISS_W'(MAX_MISSES);

    // State and data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            sw_prev_q  <= '0;
            led_q      <= '0;
            target_q   <= '0;
            presc_q    <= '0;
            react_q    <= '0;
            token_q    <= '0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            score_q    <= '0;
            miss_cnt_q <= '0;
            over_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            sw_prev_q  <= sw_prev_d;
            led_q      <= led_d;
            target_q   <= target_d;
            presc_q    <= presc_d;
            react_q    <= react_d;
            token_q    <= token_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            score_q    <= score_d;
            miss_cnt_q <= miss_cnt_d;
            over_q     <= over_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (led_onehot_c) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                if (judge_hit_c) begin
                    state_d = S_WAIT;
                end else if (judge_miss_c) begin
                    state_d = last_miss_c ? S_OVER : S_WAIT;
                end
            end
            // Hold until the LED goes dark so one LED is judged only once.
            S_WAIT: begin
                if (led_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            S_OVER: begin
                state_d = S_OVER;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_comb begin
        sync1_d    = sw;
        sync2_d    = sync1_q;
        sw_prev_d  = sync2_q;
        led_d      = led_in;
        target_d   = target_q;
        presc_d    = presc_q;
        react_d    = react_q;
        token_d    = token_q;
        hit_d      = 1'b0;
        miss_d     = 1'b0;
        score_d    = score_q;
        miss_cnt_d = miss_cnt_q;
        over_d     = over_q;
        busy_d     = (state_d == S_ARMED);

        unique case (state_q)
            S_IDLE: begin
                if (led_onehot_c) begin
                    target_d = led_q;
                    presc_d  = '0;
                    react_d  = '0;
                end
            end
            S_ARMED: begin
                // Reaction tick counter, saturating at 255.
                if (presc_q == PRESC_W'(TICK_DIV - 1)) begin
                    presc_d = '0;
                    if (react_q != '1) begin
                        react_d = react_q + REACT_W'(1);
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end

                if (judge_hit_c) begin
                    token_d = react_q;
                    hit_d   = 1'b1;
                    if (score_q != '1) begin
                        score_d = score_q + SCORE_W'(1);
                    end
                end else if (judge_miss_c) begin
                    token_d    = '1;
                    miss_d     = 1'b1;
                    miss_cnt_d = miss_cnt_q + MISS_W'(1);
                    if (last_miss_c) begin
                        over_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
            end
            S_OVER: begin
            end
            default: begin
            end
        endcase
    end

    assign token      = token_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign miss_count = miss_cnt_q;
    assign game_over  = over_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: scenario table, hand-written corner
// sequences, then random stimulus against an episode-level reference model.
module tb_hit_judge;

    localparam int unsigned TD = 4;
    localparam int unsigned TO = 10;
    localparam int unsigned MM = 3;
    localparam int unsigned SW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    led_in = 8'h00;
    logic [7:0]    sw = 8'h00;
    logic [7:0]    token;
    logic          hit_pulse;
    logic          miss_pulse;
    logic [SW-1:0] score;
    logic [3:0]    miss_count;
    logic          game_over;
    logic          busy;

    hit_judge #(
        .TICK_DIV      (TD),
        .TIMEOUT_TICKS (TO),
        .MAX_MISSES    (MM),
        .SCORE_W       (SW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .sw         (sw),
        .token      (token),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .miss_count (miss_count),
        .game_over  (game_over),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One LED episode: flip_at and hold are negedge indices from LED-on.
    typedef struct {
        logic [7:0] led;
        logic [7:0] mask;
        int flip_at;
        int hold;
        int e_hits;
        int e_miss;
        int e_token;
        int e_score;
        int e_mc;
        int e_at;
        int e_busy;
    } row_t;

    task automatic do_reset();
        sw     = 8'h00;
        led_in = 8'h00;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_episode(input row_t r, output int hits, output int misses,
                               output int both, output int at, output int busy_n);
        hits = 0; misses = 0; both = 0; at = -1; busy_n = 0;
        for (int n = 0; n < r.hold + 8; n++) begin
            if (n == 0)         led_in = r.led;
            if (n == r.hold)    led_in = 8'h00;
            if (n == r.flip_at) sw = sw ^ r.mask;
            @(negedge clk);
            if (hit_pulse)  hits++;
            if (miss_pulse) misses++;
            if (hit_pulse && miss_pulse) both++;
            if ((hit_pulse || miss_pulse) && at < 0) at = n + 1;
            if (busy) busy_n++;
        end
    endtask

    // Reference model: tracks each LED episode with a plain cycle count
    // since arming, converted to ticks by division.
    int         m_phase;       // 0 idle, 1 judging, 2 waiting for LED off, 3 game over
    int         m_cycles;
    logic [7:0] m_target;
    logic [7:0] m_led_hist;
    logic [7:0] m_sw_hist [3];
    int         m_token, m_score, m_mc;
    bit         m_hit, m_miss, m_over;

    task model_reset();
        m_phase = 0; m_cycles = 0; m_target = 8'h00; m_led_hist = 8'h00;
        for (int i = 0; i < 3; i++) m_sw_hist[i] = 8'h00;
        m_token = 0; m_score = 0; m_mc = 0;
        m_hit = 0; m_miss = 0; m_over = 0;
    endtask

    task model_step(input logic [7:0] li, input logic [7:0] si);
        logic [7:0] tog;
        int         ticks;
        bit         h, m;
        tog = m_sw_hist[1] ^ m_sw_hist[2];
        h = 0; m = 0;
        case (m_phase)
            0: if ($countones(m_led_hist) == 1) begin
                   m_target = m_led_hist; m_cycles = 0; m_phase = 1;
               end
            1: begin
                   ticks = m_cycles / TD;
                   if (ticks > 255) ticks = 255;
                   if ((tog & ~m_target) != 0)       m = 1;
                   else if (tog == m_target)         h = 1;
                   else if (m_led_hist == 0)         m = 1;
                   else if (ticks == TO)             m = 1;
                   m_cycles++;
                   if (h) begin
                       m_token = ticks;
                       if (m_score < (1 << SW) - 1) m_score++;
                       m_phase = 2;
                   end else if (m) begin
                       m_token = 255;
                       m_mc++;
                       if (m_mc == MM) begin m_over = 1; m_phase = 3; end
                       else m_phase = 2;
                   end
               end
            2: if (m_led_hist == 0) m_phase = 0;
            default: ;
        endcase
        m_hit = h; m_miss = m;
        m_sw_hist[2] = m_sw_hist[1];
        m_sw_hist[1] = m_sw_hist[0];
        m_sw_hist[0] = si;
        m_led_hist   = li;
    endtask

    initial begin
        row_t rows [10];
        row_t r;
        int hits, misses, both, at, busy_n;
        int hold_left, over_cnt, rst_cnt, rv;
        bit led_on;

        rows[0] = '{8'h04, 8'h04, 20, 30, 1, 0,   5, 1, 0, 23, 21};
        rows[1] = '{8'h10, 8'h18,  5, 30, 0, 1, 255, 0, 1,  8,  6};
        rows[2] = '{8'h01, 8'h01, -1, 12, 0, 1, 255, 0, 1, 14, 12};
        rows[3] = '{8'h01, 8'h01, 11, 12, 1, 0,   2, 1, 0, 14, 12};
        rows[4] = '{8'h80, 8'h80, -1, 60, 0, 1, 255, 0, 1, 43, 41};
        rows[5] = '{8'h0C, 8'h04,  3, 20, 0, 0,   0, 0, 0, -1,  0};
        rows[6] = '{8'h02, 8'h01,  7, 20, 0, 1, 255, 0, 1, 10,  8};
        rows[7] = '{8'h20, 8'h20,  0, 20, 1, 0,   0, 1, 0,  3,  1};
        rows[8] = '{8'h40, 8'h40, 39, 60, 1, 0,   9, 1, 0, 42, 40};
        rows[9] = '{8'h08, 8'h08, 40, 60, 1, 0,  10, 1, 0, 43, 41};

        // Reset state.
        #1;
        check("rst_token", token, 0);
        check("rst_hit", hit_pulse, 0);
        check("rst_miss", miss_pulse, 0);
        check("rst_score", score, 0);
        check("rst_mc", miss_count, 0);
        check("rst_over", game_over, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Scenario table, each from a fresh reset.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            run_episode(rows[i], hits, misses, both, at, busy_n);
            check($sformatf("row%0d_hits", i), hits, rows[i].e_hits);
            check($sformatf("row%0d_miss", i), misses, rows[i].e_miss);
            check($sformatf("row%0d_both", i), both, 0);
            check($sformatf("row%0d_token", i), token, rows[i].e_token);
            check($sformatf("row%0d_score", i), score, rows[i].e_score);
            check($sformatf("row%0d_mc", i), miss_count, rows[i].e_mc);
            check($sformatf("row%0d_at", i), at, rows[i].e_at);
            check($sformatf("row%0d_busy", i), busy_n, rows[i].e_busy);
        end

        // Game over after three expiries, then no further judgement.
        do_reset();
        r = '{8'h01, 8'h00, -1, 8, 0, 1, 255, 0, 0, 10, 8};
        for (int k = 1; k <= 3; k++) begin
            run_episode(r, hits, misses, both, at, busy_n);
            check($sformatf("go_miss%0d", k), misses, 1);
            check($sformatf("go_mc%0d", k), miss_count, k);
            check($sformatf("go_flag%0d", k), game_over, (k == 3) ? 1 : 0);
        end
        r = '{8'h04, 8'h04, 5, 20, 0, 0, 0, 0, 0, -1, 0};
        run_episode(r, hits, misses, both, at, busy_n);
        check("over_hits", hits, 0);
        check("over_miss", misses, 0);
        check("over_busy", busy_n, 0);
        check("over_token", token, 255);
        check("over_hold", game_over, 1);
        rst = 1'b1;
        #1;
        check("over_rst_token", token, 0);
        check("over_rst_mc", miss_count, 0);
        check("over_rst_flag", game_over, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a judgement.
        do_reset();
        r = '{8'h04, 8'h04, 6, 15, 1, 0, 1, 1, 0, 9, 7};
        run_episode(r, hits, misses, both, at, busy_n);
        check("mid_pre_score", score, 1);
        led_in = 8'h02;
        repeat (10) @(negedge clk);
        check("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_score", score, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_token", token, 0);
        hits = 0;
        repeat (3) begin
            @(negedge clk);
            if (hit_pulse || miss_pulse) hits++;
        end
        check("mid_no_pulse", hits, 0);
        rst = 1'b0;

        // Random stimulus against the model.
        do_reset();
        model_reset();
        hold_left = 0; over_cnt = 0; rst_cnt = 0; led_on = 0;
        for (int c = 0; c < 8000; c++) begin
            if (rst_cnt == 0 && (over_cnt > 25 || $urandom_range(0, 599) == 0))
                rst_cnt = 2;
            if (rst_cnt > 0) begin rst = 1'b1; rst_cnt--; end
            else rst = 1'b0;

            if (hold_left == 0) begin
                if (led_on) begin
                    led_in = 8'h00; hold_left = $urandom_range(1, 6); led_on = 0;
                end else begin
                    rv = $urandom_range(0, 19);
                    if (rv < 2) led_in = 8'($urandom_range(0, 255));
                    else        led_in = 8'd1 << $urandom_range(0, 7);
                    hold_left = $urandom_range(1, 60); led_on = 1;
                end
            end else begin
                hold_left--;
            end
            rv = $urandom_range(0, 29);
            if (rv == 0)                 sw = sw ^ (8'd1 << $urandom_range(0, 7));
            else if (rv < 3 && led_on)   sw = sw ^ led_in;

            @(posedge clk);
            if (rst) model_reset();
            else     model_step(led_in, sw);
            @(negedge clk);
            total++;
            if (hit_pulse !== m_hit || miss_pulse !== m_miss || token !== 8'(m_token) ||
                score !== SW'(m_score) || miss_count !== 4'(m_mc) ||
                game_over !== m_over || busy !== (m_phase == 1)) begin
                bad++;
                $display("FAIL rand c=%0d: got h=%0b m=%0b tok=%0d sc=%0d mc=%0d go=%0b busy=%0b expected h=%0b m=%0b tok=%0d sc=%0d mc=%0d go=%0b busy=%0b",
                         c, hit_pulse, miss_pulse, token, score, miss_count, game_over, busy,
                         m_hit, m_miss, m_token, m_score, m_mc, m_over, (m_phase == 1));
            end
            over_cnt = m_over ? over_cnt + 1 : 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hit_judge.md
Name: hit_judge

Overview:
- Downstream consumer of the LED randomizer in the hit-or-miss game.
- Watches the one-hot LED vector and the player's switches, and judges each lit LED as a hit or a miss.
- Measures reaction time in coarse ticks and returns it as the 8-bit token fed back to the randomizer.
- Keeps score, counts misses and ends the game after a configurable number of misses.

Parameters:
- TICK_DIV, 50000, clk cycles per reaction tick (1 ms at 50 MHz); must be >= 2.
- TIMEOUT_TICKS, 255, reaction ticks before an unanswered LED is judged a miss; range 1..255.
- MAX_MISSES, 3, misses that end the game; range 1..15.
- SCORE_W, 8, score counter width.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- led_in, input, 8, one-hot LED vector from the randomizer; 0 = no LED lit.
- sw, input, 8, raw asynchronous player switches.
- token, output, 8, last reaction time in ticks; 8'hFF after a miss.
- hit_pulse, output, 1, one-clk pulse per hit.
- miss_pulse, output, 1, one-clk pulse per miss.
- score, output, SCORE_W, hit count, saturating.
- miss_count, output, 4, miss count.
- game_over, output, 1, high once miss_count reaches MAX_MISSES.
- busy, output, 1, high while in ARMED.

Behaviour:
- Reset: async on rst. Clears all registers: token=0, score=0, miss_count=0, hit_pulse=0, miss_pulse=0, game_over=0, busy=0. State=IDLE. Sync flops, sw_prev and led_q all 0.
- Switch path:
  - sw passes through a 2-flop synchronizer to give sw_s; sw_prev <= sw_s every clk.
  - toggles = sw_s ^ sw_prev; either edge direction counts as a flip.
- LED path: led_q <= led_in every clk; all decisions use led_q.
- IDLE:
  - If led_q is exactly one-hot: target <= led_q, prescaler=0, react_cnt=0, go to ARMED.
  - led_q == 0 or multi-hot: stay in IDLE.
  - Toggles are ignored, with no penalty.
- ARMED (busy=1):
  - Prescaler counts 0..TICK_DIV-1. On wrap, react_cnt increments, saturating at 255.
  - Judgement, first match wins each clk:
    1. toggles has any bit outside target -> MISS (wrong switch beats a simultaneous correct flip).
    2. toggles == target -> HIT.
    3. led_q == 0 -> MISS (LED expired). A flip arriving in the same cycle as LED-off is judged by rules 1/2.
    4. react_cnt == TIMEOUT_TICKS -> MISS.
- HIT action (registered, one clk):
  - token <= react_cnt.
  - hit_pulse=1 for exactly one clk.
  - score += 1, saturating at all-ones.
  - Go to WAIT.
- MISS action (registered, one clk):
  - token <= 8'hFF.
  - miss_pulse=1 for exactly one clk.
  - miss_count += 1.
  - If the new miss_count == MAX_MISSES: game_over <= 1, go to OVER. Otherwise go to WAIT.
- WAIT: stay until led_q == 0, then go to IDLE, so one LED is judged once. Toggles are ignored.
- OVER: terminal state; exit only by rst. Outputs hold, pulses stay 0, inputs are ignored.
- Latency: a sw change setup before rising edge k gives hit_pulse/miss_pulse high in the cycle after edge k+2.
- Pulse timing:
  - token updates on the same edge the pulse rises.
  - token holds its value until the next judgement.
  - hit_pulse and miss_pulse are never high together.
- Reset mid-ARMED: returns to IDLE with counters cleared, no pulse.
- Switches already up at reset produce a toggle while in IDLE; it is ignored.

Test Plan (TICK_DIV=4, TIMEOUT_TICKS=10, MAX_MISSES=3):
- Scenario 1, correct hit: led_in=8'h04; flip sw[2] after 20 clk in ARMED -> hit_pulse once, token=5, score=1, miss_count=0.
- Scenario 2, wrong switch: led_in=8'h10; flip sw[3] and sw[4] in the same clk -> miss_pulse once, token=8'hFF, miss_count=1, score unchanged.
- Scenario 3, LED expiry and flip/LED-off tie:
  - led_in=8'h01 held 12 clk, then 0, no flips -> miss via expiry.
  - Repeat, but sw[0] flips in the same cycle led_q clears -> hit.
- Scenario 4, timeout: led_in=8'h80 held, no flips -> miss_pulse after exactly 40 clk in ARMED, token=8'hFF, return to IDLE only after led_in=0.
- Scenario 5, game over and recovery:
  - Three consecutive misses -> game_over=1 on the third; a further LED plus correct flip gives no pulse.
  - rst clears every output to 0.
- Scenario 6, invalid LED and reset mid-ARMED:
  - led_in=8'h0C -> stays IDLE, busy=0.
  - Separately, assert rst mid-ARMED -> IDLE, no pulse, score=0.
